// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: selects hold / +1 / branch / jump / trap next PC and owns the PC register.
// Optional trap support (trap_i, epc_o) is enabled by defining FETCH_SEQ_TRAP_EN.
module fetch_sequencer #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1,
  parameter logic [PC_W-1:0] TRAP_VEC     = PC_W'('h10)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_target_i,
  input  logic            halt_i,
  input  logic            resume_i,
`ifdef FETCH_SEQ_TRAP_EN
  input  logic            trap_i,
  output logic [PC_W-1:0] epc_o,
`endif
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_next_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, REDIR = 2'd2, HALT = 2'd3} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES);

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            trap;
  logic            redirect;
  logic [PC_W-1:0] target;

`ifdef FETCH_SEQ_TRAP_EN
  logic [PC_W-1:0] epc, epc_nxt;
  assign trap  = trap_i;
  assign epc_o = epc;
`else
  assign trap = 1'b0;
`endif

  // Redirect priority among the sources: trap > branch > jump
  assign redirect = trap | br_taken_i | jmp_i;
  assign target   = trap ? TRAP_VEC : (br_taken_i ? br_target_i : jmp_target_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc_o  <= RESET_PC;
      cnt   <= '0;
`ifdef FETCH_SEQ_TRAP_EN
      epc   <= '0;
`endif
    end else begin
      state <= state_nxt;
      pc_o  <= pc_nxt;
      cnt   <= cnt_nxt;
`ifdef FETCH_SEQ_TRAP_EN
      epc   <= epc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_o;
    cnt_nxt   = cnt;
`ifdef FETCH_SEQ_TRAP_EN
    epc_nxt   = epc;
`endif
    case (state)
      BOOT: state_nxt = RUN;
      RUN, REDIR: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = REDIR;
          cnt_nxt   = CNT_LOAD;
`ifdef FETCH_SEQ_TRAP_EN
          if (trap) epc_nxt = pc_o;
`endif
        end else if (state == RUN) begin
          if (halt_i)        state_nxt = HALT;
          else if (!stall_i) pc_nxt    = pc_o + PC_W'(1);
        end else if (cnt <= 4'd1) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HALT: begin
        // A trap wakes a halted core; ordinary branches and jumps do not
        if (trap) begin
          pc_nxt    = TRAP_VEC;
          state_nxt = REDIR;
          cnt_nxt   = CNT_LOAD;
        end else if (resume_i && !halt_i) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid_o = (state == RUN);
    flush_o       = (state == REDIR);
    state_o       = state;
    pc_next_o     = pc_nxt;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed stimulus, per-cycle model comparison and literal spot checks.
module tb_fetch_sequencer;
  localparam int          PC_W  = 32;
  localparam int          FLUSH = 2;
  localparam logic [31:0] RPC   = 32'h0;
  localparam logic [31:0] TVEC  = 32'h10;

  logic        clk = 1'b0;
  logic        reset, stall, br, jmp, halt, resume, trap;
  logic [31:0] br_t, jmp_t;
  logic [31:0] pc, pc_next, epc;
  logic        fv, flush;
  logic [1:0]  state;

  fetch_sequencer #(.PC_W(PC_W), .RESET_PC(RPC), .FLUSH_CYCLES(FLUSH), .TRAP_VEC(TVEC)) dut (
    .clk(clk), .reset(reset), .stall_i(stall), .br_taken_i(br), .br_target_i(br_t),
    .jmp_i(jmp), .jmp_target_i(jmp_t), .halt_i(halt), .resume_i(resume),
`ifdef FETCH_SEQ_TRAP_EN
    .trap_i(trap), .epc_o(epc),
`endif
    .pc_o(pc), .pc_next_o(pc_next), .fetch_valid_o(fv), .flush_o(flush), .state_o(state)
  );

`ifndef FETCH_SEQ_TRAP_EN
  assign epc = 32'h0;
`endif

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode is held as booting/halted flags plus remaining bubble count
  logic [31:0] m_pc, m_epc;
  bit          m_boot, m_halt, m_known;
  int          m_left;

  function automatic logic [31:0] m_next_pc();
    if (m_boot) return m_pc;
    if (m_halt) return trap ? TVEC : m_pc;
    if (trap) return TVEC;
    if (br)   return br_t;
    if (jmp)  return jmp_t;
    if (m_left > 0 || halt || stall) return m_pc;
    return m_pc + 32'd1;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_boot) return 2'd0;
    if (m_halt) return 2'd3;
    if (m_left > 0) return 2'd2;
    return 2'd1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_known <= 1'b1;
      m_pc    <= RPC;
      m_epc   <= 32'h0;
      m_boot  <= 1'b1;
      m_halt  <= 1'b0;
      m_left  <= 0;
    end else if (m_known) begin
      m_pc <= m_next_pc();
      if (m_boot) begin
        m_boot <= 1'b0;
      end else if (m_halt) begin
        if (trap) begin
          m_halt <= 1'b0;
          m_left <= FLUSH;
        end else if (resume && !halt) begin
          m_halt <= 1'b0;
        end
      end else if (trap || br || jmp) begin
        m_left <= FLUSH;
        if (trap) m_epc <= m_pc;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (halt) begin
        m_halt <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("pc_o", pc, m_pc);
      check("pc_next_o", pc_next, m_next_pc());
      check("state_o", {30'b0, state}, {30'b0, m_state()});
      check("fetch_valid_o", {31'b0, fv}, {31'b0, m_state() == 2'd1});
      check("flush_o", {31'b0, flush}, {31'b0, m_state() == 2'd2});
`ifdef FETCH_SEQ_TRAP_EN
      check("epc_o", epc, m_epc);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    stall = 0; br = 0; jmp = 0; halt = 0; resume = 0; trap = 0;
  endtask

  initial begin
    reset = 1; clear(); br_t = 0; jmp_t = 0;
    step(2);
    check("rst_pc", pc, 32'h0);
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_fv", {31'b0, fv}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);

    // Free run out of BOOT
    reset = 0;
    step(1); check("boot_exit_pc", pc, 32'h0); check("run_fv", {31'b0, fv}, 32'd1);
    step(1); check("run_pc1", pc, 32'h1);
    step(1); check("run_pc2", pc, 32'h2);
    step(3); check("run_pc5", pc, 32'h5);

    // Stall three cycles
    stall = 1;
    step(3); check("stall_pc", pc, 32'h5); check("stall_fv", {31'b0, fv}, 32'd1);
    stall = 0;
    step(1); check("after_stall", pc, 32'h6);
    step(1); check("pre_branch", pc, 32'h7);

    // Branch with two bubbles
    br = 1; br_t = 32'h40;
    #1 check("br_pc_next", pc_next, 32'h40);
    step(1); check("br_pc", pc, 32'h40); check("br_flush1", {31'b0, flush}, 32'd1);
    br = 0;
    step(1); check("br_flush2", {31'b0, flush}, 32'd1); check("br_fv2", {31'b0, fv}, 32'd0);
    step(1); check("br_resume_fv", {31'b0, fv}, 32'd1); check("br_resume_pc", pc, 32'h40);
    step(1); check("br_pc41", pc, 32'h41);

    // Priority: branch beats jump and stall
    br = 1; br_t = 32'h20; jmp = 1; jmp_t = 32'h30; stall = 1;
    step(1); check("prio_pc", pc, 32'h20);
    clear(); stall = 1; halt = 1;
    step(1); check("redir_ignores_halt", {30'b0, state}, 32'd2);
    clear(); jmp = 1; jmp_t = 32'h60;
    step(1); check("re_redirect_pc", pc, 32'h60);
    clear();
    step(1); check("re_redirect_hold", {30'b0, state}, 32'd2);
    step(1); check("re_redirect_run", {30'b0, state}, 32'd1);

    // Wrap at all-ones
    jmp = 1; jmp_t = 32'hFFFF_FFFF;
    step(1); clear();
    step(2); check("wrap_pre", pc, 32'hFFFF_FFFF);
    step(1); check("wrap_zero", pc, 32'h0);
    step(2); check("pre_halt", pc, 32'h2);

    // Halt, ignored inputs, halt+resume, resume
    halt = 1;
    step(1); check("halt_state", {30'b0, state}, 32'd3); check("halt_fv", {31'b0, fv}, 32'd0);
    clear(); br = 1; br_t = 32'h80; jmp = 1; stall = 1;
    step(1); check("halt_ignores_br", pc, 32'h2);
    clear(); halt = 1; resume = 1;
    step(1); check("halt_resume_both", {30'b0, state}, 32'd3);
    clear(); resume = 1;
    step(1); check("resume_pc", pc, 32'h2); check("resume_state", {30'b0, state}, 32'd1);
    clear();
    step(1); check("resume_inc", pc, 32'h3);

    // Reset during REDIR and during HALT
    br = 1; br_t = 32'h70;
    step(1); clear(); reset = 1;
    step(1); check("rst_redir_pc", pc, 32'h0); check("rst_redir_flush", {31'b0, flush}, 32'd0);
    reset = 0; halt = 0;
    step(1); halt = 1;
    step(1); check("halt_again", {30'b0, state}, 32'd3);
    clear(); reset = 1;
    step(1); check("rst_halt_state", {30'b0, state}, 32'd0);
    reset = 0;
    step(2); check("post_rst_pc", pc, 32'h1);

`ifdef FETCH_SEQ_TRAP_EN
    step(8); check("pre_trap", pc, 32'h9);
    trap = 1;
    step(1); check("trap_pc", pc, 32'h10); check("trap_epc", epc, 32'h9);
    check("trap_flush", {31'b0, flush}, 32'd1);
    trap = 0; reset = 1;
    step(1); check("trap_rst_pc", pc, 32'h0); check("trap_rst_flush", {31'b0, flush}, 32'd0);
    reset = 0;
    step(2); halt = 1;
    step(1); halt = 0; trap = 1;
    step(1); check("trap_wake_pc", pc, 32'h10); check("trap_wake_state", {30'b0, state}, 32'd2);
    trap = 0;
    step(2); check("trap_wake_run", {30'b0, state}, 32'd1);
`endif

    step(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
